// File: rtl/ds1302_time_scheduler.sv
// rtl/ds1302_time_scheduler.sv - DS1302 read/write request sequencer with periodic reads and set arbitration
module ds1302_time_scheduler #(
  parameter int unsigned READ_PERIOD = 5_000_000,
  parameter int unsigned TIMEOUT     = 1_000_000,
  parameter bit          AUTO_INIT   = 1'b1,
  parameter logic [55:0] INIT_TIME   = 56'h19_02_06_11_00_00_00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_req,
  input  logic [55:0] set_time,
  output logic        set_ready,
  output logic        write_time_req,
  input  logic        write_time_ack,
  output logic [55:0] write_time,
  output logic        read_time_req,
  input  logic        read_time_ack,
  input  logic [55:0] read_time,
  output logic [55:0] time_now,
  output logic        time_valid,
  output logic        err
);

  localparam int PW = $clog2(READ_PERIOD);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] PER_LAST = PW'(READ_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_CHECK, ST_WRITE} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] per_cnt;
  logic [TW-1:0] to_cnt;
  logic          set_pending, init_pend, init_done;
  logic          rd_ack, wr_ack, to_hit, set_take, enter_read, enter_write;

  // Acks only count while the matching request is actually on the wire.
  assign rd_ack      = (state == ST_READ)  && read_time_req  && read_time_ack;
  assign wr_ack      = (state == ST_WRITE) && write_time_req && write_time_ack;
  assign to_hit      = ((state == ST_READ) || (state == ST_WRITE)) && (to_cnt == TO_LAST)
                       && !rd_ack && !wr_ack;
  assign set_take    = set_req && set_ready;
  assign enter_read  = (state_nx == ST_READ)  && (state != ST_READ);
  assign enter_write = (state_nx == ST_WRITE) && (state != ST_WRITE);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (set_pending || init_pend)  state_nx = ST_WRITE;
        else if (per_cnt == PER_LAST)  state_nx = ST_READ;
      end
      ST_READ: begin
        if (rd_ack)       state_nx = ST_CHECK;
        else if (to_hit)  state_nx = ST_IDLE;
      end
      ST_CHECK: state_nx = ST_IDLE;
      ST_WRITE: begin
        if (wr_ack)       state_nx = ST_READ;
        else if (to_hit)  state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_READ;
    else      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      read_time_req  <= 1'b0;
      write_time_req <= 1'b0;
      write_time     <= '0;
      time_now       <= '0;
      time_valid     <= 1'b0;
      err            <= 1'b0;
      set_ready      <= 1'b1;
      set_pending    <= 1'b0;
      init_pend      <= 1'b0;
      init_done      <= 1'b0;
      per_cnt        <= '0;
      to_cnt         <= '0;
    end else begin
      // Requests rise one cycle after entering their state and drop on the leaving edge.
      read_time_req  <= (state == ST_READ)  && (state_nx == ST_READ);
      write_time_req <= (state == ST_WRITE) && (state_nx == ST_WRITE);
      time_valid     <= rd_ack;
      err            <= to_hit;

      if (enter_read)                per_cnt <= '0;
      else if (per_cnt != PER_LAST)  per_cnt <= per_cnt + 1'b1;

      if (state_nx != state)                               to_cnt <= '0;
      else if ((state == ST_READ) || (state == ST_WRITE))  to_cnt <= to_cnt + 1'b1;

      if (rd_ack) time_now <= read_time;
      if (to_hit) init_done <= 1'b1;

      if ((state == ST_CHECK) && !init_done) begin
        init_done <= 1'b1;
        if (AUTO_INIT && time_now[7] && !set_pending) begin
          init_pend  <= 1'b1;
          write_time <= INIT_TIME;
        end
      end

      if (wr_ack) begin
        set_pending <= 1'b0;
        init_pend   <= 1'b0;
        set_ready   <= 1'b1;
      end
      if (to_hit && (state == ST_WRITE)) set_ready <= !set_pending;
      // An init write also blocks new sets so write_time stays stable on the bus.
      if (enter_write) set_ready <= 1'b0;

      if (set_take) begin
        write_time  <= set_time;
        set_pending <= 1'b1;
        set_ready   <= 1'b0;
        init_pend   <= 1'b0;
      end
    end
  end

endmodule
